// File: rtl/rgb_seq_pkg.sv
// Shared types and constants for the RGB block sequencer.
package rgb_seq_pkg;
  localparam int PIXELS_PER_BLOCK = 64;
  localparam int PIX_W            = 8;
  localparam int PIX_IDX_W        = 6;

  typedef enum logic [1:0] {
    FILL = 2'd0,
    CONV = 2'd1,
    OUT  = 2'd2
  } state_e;
endpackage

// File: rtl/rgb_seq_fsm.sv
// Control for the block sequencer: FILL/CONV/OUT state, pixel and latency counters.
module rgb_seq_fsm
  import rgb_seq_pkg::*;
#(
  parameter int CONV_LATENCY = 3
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 s_valid,
  input  logic                 m_ready,
  output logic                 s_ready,
  output logic                 m_valid,
  output logic                 busy,
  output logic                 accept,
  output logic                 capture,
  output logic [PIX_IDX_W-1:0] pix_cnt
);
  localparam int LAT_W = $clog2(CONV_LATENCY + 1);

  state_e           state;
  logic [LAT_W-1:0] lat_cnt;
  logic             lat_done;

  assign s_ready  = (state == FILL);
  assign m_valid  = (state == OUT);
  assign accept   = s_valid & s_ready;
  assign lat_done = (lat_cnt == LAT_W'(CONV_LATENCY - 1));
  assign capture  = (state == CONV) && lat_done;
  assign busy     = (state != FILL) || (pix_cnt != '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= FILL;
      pix_cnt <= '0;
      lat_cnt <= '0;
    end else begin
      case (state)
        FILL: begin
          if (accept) begin
            // pix_cnt wraps 63 -> 0 on the last pixel of the block
            pix_cnt <= pix_cnt + 1'b1;
            if (pix_cnt == PIX_IDX_W'(PIXELS_PER_BLOCK - 1)) begin
              state   <= CONV;
              lat_cnt <= '0;
            end
          end
        end
        CONV: begin
          lat_cnt <= lat_cnt + 1'b1;
          if (lat_done) state <= OUT;
        end
        OUT: begin
          if (m_ready) state <= FILL;
        end
        default: state <= FILL;
      endcase
    end
  end
endmodule

// File: rtl/rgb_block_sequencer.sv
// Gathers 64 RGB pixels for the conversion array and presents its Y/Cb/Cr results as one block.
// Optional performance counters (blk_cnt, stall_cnt) are enabled with RGB_SEQ_PERF_EN.
module rgb_block_sequencer
  import rgb_seq_pkg::*;
#(
  parameter int FIXED_POINT_LENGTH = 32,
  parameter int CONV_LATENCY       = 3,
  parameter int PIXELS             = 64
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             s_valid,
  output logic                             s_ready,
  input  logic [PIX_W-1:0]                 s_r,
  input  logic [PIX_W-1:0]                 s_g,
  input  logic [PIX_W-1:0]                 s_b,
  output logic [PIX_W*PIXELS-1:0]          conv_r_all,
  output logic [PIX_W*PIXELS-1:0]          conv_g_all,
  output logic [PIX_W*PIXELS-1:0]          conv_b_all,
  input  logic [FIXED_POINT_LENGTH*PIXELS-1:0] conv_y_all,
  input  logic [FIXED_POINT_LENGTH*PIXELS-1:0] conv_cb_all,
  input  logic [FIXED_POINT_LENGTH*PIXELS-1:0] conv_cr_all,
  output logic                             m_valid,
  input  logic                             m_ready,
  output logic [FIXED_POINT_LENGTH*PIXELS-1:0] m_y_all,
  output logic [FIXED_POINT_LENGTH*PIXELS-1:0] m_cb_all,
  output logic [FIXED_POINT_LENGTH*PIXELS-1:0] m_cr_all,
`ifdef RGB_SEQ_PERF_EN
  output logic [31:0]                      blk_cnt,
  output logic [31:0]                      stall_cnt,
`endif
  output logic                             busy
);
  logic                 accept;
  logic                 capture;
  logic [PIX_IDX_W-1:0] pix_cnt;

  rgb_seq_fsm #(
    .CONV_LATENCY(CONV_LATENCY)
  ) u_fsm (
    .clk     (clk),
    .rst     (rst),
    .s_valid (s_valid),
    .m_ready (m_ready),
    .s_ready (s_ready),
    .m_valid (m_valid),
    .busy    (busy),
    .accept  (accept),
    .capture (capture),
    .pix_cnt (pix_cnt)
  );

  // Block registers feed the array directly and only change while filling.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      conv_r_all <= '0;
      conv_g_all <= '0;
      conv_b_all <= '0;
    end else if (accept) begin
      conv_r_all[PIX_W*pix_cnt +: PIX_W] <= s_r;
      conv_g_all[PIX_W*pix_cnt +: PIX_W] <= s_g;
      conv_b_all[PIX_W*pix_cnt +: PIX_W] <= s_b;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      m_y_all  <= '0;
      m_cb_all <= '0;
      m_cr_all <= '0;
    end else if (capture) begin
      m_y_all  <= conv_y_all;
      m_cb_all <= conv_cb_all;
      m_cr_all <= conv_cr_all;
    end
  end

`ifdef RGB_SEQ_PERF_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      blk_cnt   <= '0;
      stall_cnt <= '0;
    end else begin
      if (m_valid && m_ready) blk_cnt <= blk_cnt + 32'd1;
      if (m_valid && !m_ready && (stall_cnt != '1)) stall_cnt <= stall_cnt + 32'd1;
    end
  end
`endif
endmodule

// File: tb/tb_rgb_block_sequencer.sv
// Directed bench for rgb_block_sequencer with a two-register-stage array model.
module tb_rgb_block_sequencer;
  localparam int FPL = 32;
  localparam int NP  = 64;

  logic              clk = 1'b0;
  logic              rst;
  logic              s_valid, s_ready, m_valid, m_ready, busy;
  logic [7:0]        s_r, s_g, s_b;
  logic [8*NP-1:0]   conv_r_all, conv_g_all, conv_b_all;
  logic [FPL*NP-1:0] conv_y_all, conv_cb_all, conv_cr_all;
  logic [FPL*NP-1:0] m_y_all, m_cb_all, m_cr_all;
  logic [FPL*NP-1:0] arr_y, arr_cb, arr_cr, p1_y, p1_cb, p1_cr, p2_y, p2_cb, p2_cr;
`ifdef RGB_SEQ_PERF_EN
  logic [31:0]       blk_cnt, stall_cnt;
`endif

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  rgb_block_sequencer #(.FIXED_POINT_LENGTH(FPL), .CONV_LATENCY(3), .PIXELS(NP)) dut (
    .clk(clk), .rst(rst), .s_valid(s_valid), .s_ready(s_ready),
    .s_r(s_r), .s_g(s_g), .s_b(s_b),
    .conv_r_all(conv_r_all), .conv_g_all(conv_g_all), .conv_b_all(conv_b_all),
    .conv_y_all(conv_y_all), .conv_cb_all(conv_cb_all), .conv_cr_all(conv_cr_all),
    .m_valid(m_valid), .m_ready(m_ready),
    .m_y_all(m_y_all), .m_cb_all(m_cb_all), .m_cr_all(m_cr_all),
`ifdef RGB_SEQ_PERF_EN
    .blk_cnt(blk_cnt), .stall_cnt(stall_cnt),
`endif
    .busy(busy)
  );

  // Array model: outputs valid just before the third edge after inputs settle.
  always_comb begin
    arr_y = '0; arr_cb = '0; arr_cr = '0;
    for (int i = 0; i < NP; i++) begin
      arr_y[FPL*i +: FPL]  = {8'h11, conv_r_all[8*i +: 8], conv_g_all[8*i +: 8], conv_b_all[8*i +: 8]};
      arr_cb[FPL*i +: FPL] = {8'h22, conv_g_all[8*i +: 8], conv_b_all[8*i +: 8], conv_r_all[8*i +: 8]};
      arr_cr[FPL*i +: FPL] = {8'h33, conv_b_all[8*i +: 8], conv_r_all[8*i +: 8], conv_g_all[8*i +: 8]};
    end
  end
  always_ff @(posedge clk) begin
    p1_y <= arr_y;  p1_cb <= arr_cb; p1_cr <= arr_cr;
    p2_y <= p1_y;   p2_cb <= p1_cb;  p2_cr <= p1_cr;
  end
  assign conv_y_all  = p2_y;
  assign conv_cb_all = p2_cb;
  assign conv_cr_all = p2_cr;

  function automatic logic [7:0] pix(input int pat, input int i, input int ch);
    logic [7:0] b8;
    b8 = 8'(i);
    case (pat)
      1:       return (ch == 0) ? b8 : (ch == 1) ? 8'(2*i) : 8'(255 - i);
      2:       return (ch == 0) ? 8'(3*i + 7) : (ch == 1) ? (b8 ^ 8'h5A) : 8'(200 - i);
      3:       return (ch == 0) ? ~b8 : (ch == 1) ? 8'(i + 100) : 8'(i*5);
      default: return (ch == 0) ? 8'(i*7 + pat) : (ch == 1) ? 8'(i + pat*16) : 8'(250 - 2*i);
    endcase
  endfunction

  function automatic logic [8*NP-1:0] exp_rgb(input int pat, input int ch);
    logic [8*NP-1:0] v;
    v = '0;
    for (int i = 0; i < NP; i++) v[8*i +: 8] = pix(pat, i, ch);
    return v;
  endfunction

  function automatic logic [FPL*NP-1:0] exp_ycc(input int pat, input int k);
    logic [FPL*NP-1:0] v;
    logic [7:0] r, g, b;
    v = '0;
    for (int i = 0; i < NP; i++) begin
      r = pix(pat, i, 0); g = pix(pat, i, 1); b = pix(pat, i, 2);
      case (k)
        0:       v[FPL*i +: FPL] = {8'h11, r, g, b};
        1:       v[FPL*i +: FPL] = {8'h22, g, b, r};
        default: v[FPL*i +: FPL] = {8'h33, b, r, g};
      endcase
    end
    return v;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_blk(input string tag, input logic [FPL*NP-1:0] obs, input logic [FPL*NP-1:0] exp);
    int idx;
    idx = 0;
    for (int i = NP - 1; i >= 0; i--)
      if (obs[FPL*i +: FPL] !== exp[FPL*i +: FPL]) idx = i;
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: word %0d got %h expected %h", tag, idx, obs[FPL*idx +: FPL], exp[FPL*idx +: FPL]);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Ends one time step after the edge that accepted the last requested pixel.
  task automatic feed(input int pat, input int count, input bit gaps, output int mv_seen);
    int n;
    int cyc;
    logic acc;
    n = 0; cyc = 0; mv_seen = 0;
    while (n < count && cyc < 400) begin
      if (!gaps || (cyc % 2 == 0)) begin
        s_valid = 1'b1;
        s_r = pix(pat, n, 0); s_g = pix(pat, n, 1); s_b = pix(pat, n, 2);
      end else begin
        s_valid = 1'b0;
        s_r = 'x; s_g = 'x; s_b = 'x;
      end
      acc = s_valid & s_ready;
      if (m_valid) mv_seen++;
      tick();
      cyc++;
      if (acc) n++;
    end
    s_valid = 1'b0;
    chk("feed_accepts", n, count);
  endtask

  task automatic chk_slots(input string tag, input int pat);
    chk_blk({tag, "_r"}, (FPL*NP)'(conv_r_all), (FPL*NP)'(exp_rgb(pat, 0)));
    chk_blk({tag, "_g"}, (FPL*NP)'(conv_g_all), (FPL*NP)'(exp_rgb(pat, 1)));
    chk_blk({tag, "_b"}, (FPL*NP)'(conv_b_all), (FPL*NP)'(exp_rgb(pat, 2)));
  endtask

  initial begin
    int mv;
    int bad;
    int acc_cnt;
    logic rdy64;
    logic [FPL*NP-1:0] saved;

    rst = 1'b1; s_valid = 1'b0; m_ready = 1'b0; s_r = '0; s_g = '0; s_b = '0;
    #1;
    chk("rst_s_ready", s_ready, 1);
    chk("rst_m_valid", m_valid, 0);
    chk("rst_busy", busy, 0);
    chk_blk("rst_m_y", m_y_all, '0);
    tick(); tick();
    rst = 1'b0;
    tick();

    // Block 1: back-to-back, then 10 cycles of backpressure
    feed(1, 64, 1'b0, mv);
    chk_slots("b1_slot", 1);
    tick(); tick();
    chk("b1_mvalid_early", m_valid, 0);
    chk("b1_s_ready_conv", s_ready, 0);
    chk("b1_busy_conv", busy, 1);
    tick();
    chk("b1_mvalid", m_valid, 1);
    chk_blk("b1_y", m_y_all, exp_ycc(1, 0));
    chk_blk("b1_cb", m_cb_all, exp_ycc(1, 1));
    chk_blk("b1_cr", m_cr_all, exp_ycc(1, 2));
    saved = m_y_all;
    bad = 0;
    repeat (10) begin
      tick();
      if (s_ready !== 1'b0 || m_valid !== 1'b1 || m_y_all !== saved) bad++;
    end
    chk("b1_bp_stable", bad, 0);
`ifdef RGB_SEQ_PERF_EN
    chk("b1_stall_cnt", stall_cnt, 10);
`endif
    m_ready = 1'b1;
    tick();
    chk("b1_mvalid_after_hs", m_valid, 0);
    chk("b1_s_ready_after_hs", s_ready, 1);
    chk("b1_busy_after_hs", busy, 0);

    // Block 2: source gaps with X data, m_ready held high before OUT
    feed(2, 64, 1'b1, mv);
    chk_slots("b2_slot", 2);
    tick(); tick();
    chk("b2_mvalid_early", m_valid, 0);
    tick();
    chk("b2_mvalid", m_valid, 1);
    chk_blk("b2_y", m_y_all, exp_ycc(2, 0));
    chk_blk("b2_cr", m_cr_all, exp_ycc(2, 2));
    tick();
    chk("b2_hs_first_cycle", m_valid, 0);
    chk("b2_s_ready", s_ready, 1);

    // Block 3: overrun, s_valid high for 70 cycles while downstream stalls
    m_ready = 1'b0;
    acc_cnt = 0; rdy64 = 1'bx;
    for (int c = 0; c < 70; c++) begin
      s_valid = 1'b1;
      s_r = (c < 64) ? pix(3, c, 0) : 8'hEE;
      s_g = (c < 64) ? pix(3, c, 1) : 8'hEE;
      s_b = (c < 64) ? pix(3, c, 2) : 8'hEE;
      if (s_ready) acc_cnt++;
      if (c == 64) rdy64 = s_ready;
      tick();
    end
    chk("ov_accepts", acc_cnt, 64);
    chk("ov_s_ready_64", rdy64, 0);
    chk_slots("ov_slot", 3);
    chk("ov_mvalid", m_valid, 1);
    chk_blk("ov_y", m_y_all, exp_ycc(3, 0));
    m_ready = 1'b1;
    tick();
    chk("ov_hs_mvalid", m_valid, 0);
    chk("ov_s_ready_after_hs", s_ready, 1);
    chk_slots("ov_slot_kept", 3);
    s_valid = 1'b0;
    m_ready = 1'b0;
`ifdef RGB_SEQ_PERF_EN
    chk("ov_blk_cnt", blk_cnt, 3);
    chk("ov_stall_cnt", stall_cnt, 13);
`endif

    // Mid-block reset after 30 pixels, then a full new block
    tick();
    feed(4, 30, 1'b0, mv);
    chk("mr_busy_partial", busy, 1);
    #2 rst = 1'b1;
    #1;
    chk("mr_s_ready", s_ready, 1);
    chk("mr_m_valid", m_valid, 0);
    chk("mr_busy", busy, 0);
    chk_blk("mr_m_y", m_y_all, '0);
`ifdef RGB_SEQ_PERF_EN
    chk("mr_blk_cnt_rst", blk_cnt, 0);
`endif
    tick();
    rst = 1'b0;
    m_ready = 1'b1;
    tick();
    feed(5, 64, 1'b0, mv);
    chk("mr_no_early_mvalid", mv, 0);
    tick(); tick(); tick();
    chk("mr_mvalid", m_valid, 1);
    chk_blk("mr_y", m_y_all, exp_ycc(5, 0));
    chk_blk("mr_cb", m_cb_all, exp_ycc(5, 1));
    bad = 0;
    repeat (6) begin
      tick();
      if (m_valid !== 1'b0) bad++;
    end
    chk("mr_single_mvalid", bad, 0);
`ifdef RGB_SEQ_PERF_EN
    chk("mr_blk_cnt", blk_cnt, 1);
    chk("mr_stall_cnt", stall_cnt, 0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
